// File: rtl/dram_sniffer_arbiter.sv
// Two-requester round-robin arbiter in front of a DRAM command port.
// It issues one command at a time, waits for read data with a timeout, and returns a one-cycle ack.
module dram_sniffer_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst_n,
  input  logic              phy_ready,
  input  logic              req0,
  input  logic              rnw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rnw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              cmd_valid,
  output logic              cmd_rnw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              grant
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_rnw_q, cmd_rnw_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic                busy_q, busy_d;
  logic                win_c;

  // On a tie the requester that did not win last time gets the grant.
  assign win_c = (req0 && req1) ? ~last_grant_q : req1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_rnw_d    = cmd_rnw_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;

    unique case (state_q)
      IDLE: begin
        if (phy_ready && (req0 || req1)) begin
          state_d      = ISSUE;
          grant_d      = win_c;
          last_grant_d = win_c;
          cmd_valid_d  = 1'b1;
          cmd_rnw_d    = win_c ? rnw1   : rnw0;
          cmd_addr_d   = win_c ? addr1  : addr0;
          cmd_wdata_d  = win_c ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        if (cmd_ack) begin
          cmd_valid_d = 1'b0;
          if (cmd_rnw_q) begin
            state_d = WAIT_RD;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
            err0_d  = 1'b0;
            err1_d  = 1'b0;
          end
        end
      end
      WAIT_RD: begin
        // Data returning on the final count still wins over the timeout.
        if (rd_valid) begin
          state_d = DONE;
          rdata_d = rd_data;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          err0_d  = 1'b0;
          err1_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          rdata_d = '0;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          err0_d  = ~grant_q;
          err1_d  = grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_rnw_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_rnw_q    <= cmd_rnw_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rnw   = cmd_rnw_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: doc/dram_sniffer_arbiter.md
DRAM_SNIFFER_ARBITER -- requirements
Module: dram_sniffer_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, DRAM command address width.
REQ-002 Parameter DATA_W, default 32, data width for write and read.
REQ-003 Parameter TIMEOUT, default 255, maximum number of cycles to wait for read data; legal range is 1..255.
REQ-004 OPB_Clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 OPB_Rst_n  in  1  reset, asynchronous and active-low.
REQ-006 phy_ready  in  1  DRAM PHY calibrated and ready; level signal.
REQ-007 reqN (N=0,1)  in  1  requester N transaction request; level signal, held until ackN.
REQ-008 rnwN  in  1  requester N direction: 1 = read, 0 = write.
REQ-009 addrN  in  ADDR_W  requester N address.
REQ-010 wdataN  in  DATA_W  requester N write data.
REQ-011 ackN  out  1  one-cycle completion pulse to requester N.
REQ-012 errN  out  1  read timeout flag; valid only in the ackN cycle.
REQ-013 rdata  out  DATA_W  read data for the granted requester; valid in the ackN cycle.
REQ-014 cmd_valid, cmd_rnw, cmd_addr[ADDR_W], cmd_wdata[DATA_W]  out  DRAM command port.
REQ-015 cmd_ack  in  1  DRAM accepts the command in any cycle where cmd_valid and cmd_ack are both high.
REQ-016 rd_valid, rd_data[DATA_W]  in  DRAM read return.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 grant  out  1  index of the current or last granted requester.

Function
REQ-019 The block SHALL implement four states: IDLE, ISSUE, WAIT_RD, DONE.
REQ-020 IDLE: the block SHALL stay in IDLE while phy_ready=0 or while no reqN is high. Otherwise it SHALL latch the winner's rnw, addr and wdata into command registers, set grant, and go to ISSUE on the next cycle.
REQ-021 Arbitration SHALL be round-robin:
  - one requester asserting: that requester wins;
  - both asserting: the requester not equal to last_grant wins;
  - last_grant SHALL update on every grant.
REQ-022 ISSUE: cmd_valid SHALL be 1, with command fields driven from the latched registers.
  - On cmd_ack, a write SHALL go to DONE and a read SHALL go to WAIT_RD.
  - cmd_valid SHALL NOT drop before cmd_ack, even if phy_ready falls.
REQ-023 Latency: the first cmd_valid SHALL be high exactly 1 cycle after the IDLE cycle in which a request is seen.
REQ-024 WAIT_RD: an 8-bit counter SHALL clear on entry and increment each cycle.
  - On rd_valid, rd_data SHALL be captured into rdata, err cleared, and the state SHALL go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1, rdata SHALL be set to 0, err set to 1, and the state SHALL go to DONE.
  - If rd_valid arrives in the same cycle as the counter reaching TIMEOUT-1, data SHALL win and err SHALL be 0.
REQ-025 DONE: for exactly one cycle, ack[grant]=1 and err[grant] SHALL equal the captured err. The other ack and err SHALL be 0. The next state SHALL be IDLE.
REQ-026 rd_valid arriving in IDLE, ISSUE, or DONE SHALL be ignored; stale data SHALL never be returned.
REQ-027 A requester that keeps reqN high after ackN SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.
REQ-028 A requester dropping reqN before its ackN SHALL NOT abort the transaction; the ack SHALL still be issued.
REQ-029 phy_ready=0 SHALL block only new grants; a transaction in flight SHALL complete.
REQ-030 rdata and errN SHALL hold their values outside the ack cycle; they are don't-care to requesters.

Reset
REQ-031 While OPB_Rst_n=0, the block SHALL asynchronously force:
  - state = IDLE;
  - cmd_valid, ack0, ack1, err0, err1, and busy = 0;
  - cmd_rnw, cmd_addr, cmd_wdata, and rdata = 0;
  - grant = 0 and last_grant = 1, so requester 0 wins the first tie;
  - counter = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction with no ack. Deassertion SHALL be synchronized externally, and the block SHALL resume in IDLE.

Verification
REQ-033 phy_ready=1; req0 write addr=0x10, wdata=0xA5A5A5A5; cmd_ack held high -> cmd_valid on cycle 1 with matching fields, DONE on cycle 2, ack0 pulse on cycle 2, err0=0.
REQ-034 req0 and req1 both held high with reads; rd_valid 3 cycles after cmd_ack -> grant order 0,1,0,1; each ack follows rd_valid by 1 cycle; rdata matches rd_data.
REQ-035 Read with no rd_valid and TIMEOUT=16 -> ack pulse 16 cycles after WAIT_RD entry with err=1 and rdata=0. A later rd_valid in IDLE produces no ack.
REQ-036 phy_ready=0 with req1 high -> no cmd_valid for 20 cycles. Raise phy_ready -> cmd_valid 1 cycle later. Drop phy_ready during ISSUE -> cmd_valid holds until cmd_ack.
REQ-037 Assert OPB_Rst_n=0 during WAIT_RD -> all outputs 0 immediately with no ack. After release, req0 and req1 tie -> req0 granted first.
